key_pulse_gen: RTL and testbench



---
 rtl/key_pulse_gen.sv | 123 ++++++++++++
 tb/tb_key_pulse_gen.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/key_pulse_gen.sv
// key_pulse_gen
//   Conditions the four raw push buttons of the race game for the per-player
//   step checkers. Each button is synchronised, debounced, and edge detected.
//   The result is a registered one-cycle press pulse per player. A left+right
//   press that rises in the same cycle is reported as 'both' only.
//
// Parameters
//   DEBOUNCE_CYCLES  stable cycles needed to accept a level change (>= 1)
//   CNT_W            debounce counter width, must hold DEBOUNCE_CYCLES-1
//
// Ports
//   clk                         system clock
//   resetn                      asynchronous active-low reset
//   enable                      game running; pulses forced low while 0
//   key_n[3:0]                  raw active-low buttons
//                               [1]=P1 left [0]=P1 right [3]=P2 left [2]=P2 right
//   left_one/right_one/both_one player one press pulses
//   left_two/right_two/both_two player two press pulses
//   pressed[3:0]                debounced active-high levels, key_n bit mapping
module key_pulse_gen #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned CNT_W           = 20
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       enable,
    input  logic [3:0] key_n,
    output logic       left_one,
    output logic       right_one,
    output logic       both_one,
    output logic       left_two,
    output logic       right_two,
    output logic       both_two,
    output logic [3:0] pressed
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [3:0]            sync1_q, sync1_d;
    logic [3:0]            sync2_q, sync2_d;
    logic [3:0]            pressed_q, pressed_d;
    logic [3:0]            prev_q, prev_d;
    logic [3:0][CNT_W-1:0] cnt_q, cnt_d;
    logic                  left_one_q, left_one_d;
    logic                  right_one_q, right_one_d;
    logic                  both_one_q, both_one_d;
    logic                  left_two_q, left_two_d;
    logic                  right_two_q, right_two_d;
    logic                  both_two_q, both_two_d;

    logic [3:0]            s;
    logic [3:0]            rise;

    always_comb begin
        sync1_d   = key_n;
        sync2_d   = sync1_q;
        s         = ~sync2_q;
        pressed_d = pressed_q;
        cnt_d     = cnt_q;

        // A single cycle of agreement clears the count, so bounces restart
        // the debounce window; press and release use the same path.
        for (int unsigned i = 0; i < 4; i++) begin
            if (s[i] == pressed_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_MAX) begin
                pressed_d[i] = s[i];
                cnt_d[i]     = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
        end

        prev_d = pressed_q;
        rise   = pressed_q & ~prev_q;

        // Only rising edges classify; a button already held does not block
        // a single pulse for the other button of the same player.
        left_one_d  = enable &  rise[1] & ~rise[0];
        right_one_d = enable &  rise[0] & ~rise[1];
        both_one_d  = enable &  rise[1] &  rise[0];
        left_two_d  = enable &  rise[3] & ~rise[2];
        right_two_d = enable &  rise[2] & ~rise[3];
        both_two_d  = enable &  rise[3] &  rise[2];
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sync1_q     <= '1;
            sync2_q     <= '1;
            pressed_q   <= '0;
            prev_q      <= '0;
            cnt_q       <= '0;
            left_one_q  <= 1'b0;
            right_one_q <= 1'b0;
            both_one_q  <= 1'b0;
            left_two_q  <= 1'b0;
            right_two_q <= 1'b0;
            both_two_q  <= 1'b0;
        end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            pressed_q   <= pressed_d;
            prev_q      <= prev_d;
            cnt_q       <= cnt_d;
            left_one_q  <= left_one_d;
            right_one_q <= right_one_d;
            both_one_q  <= both_one_d;
            left_two_q  <= left_two_d;
            right_two_q <= right_two_d;
            both_two_q  <= both_two_d;
        end
    end

    assign pressed   = pressed_q;
    assign left_one  = left_one_q;
    assign right_one = right_one_q;
    assign both_one  = both_one_q;
    assign left_two  = left_two_q;
    assign right_two = right_two_q;
    assign both_two  = both_two_q;

endmodule

// File: tb/tb_key_pulse_gen.sv
// tb_key_pulse_gen
//   Directed bench for key_pulse_gen with DEBOUNCE_CYCLES=4, CNT_W=3.
//   Inputs change 1 time unit after a rising edge, so the next rising edge
//   is "edge 0" of the new stimulus. Outputs are sampled 1 unit after edges.
//   Pulse vector order: {left_one,right_one,both_one,left_two,right_two,both_two}.
module tb_key_pulse_gen;

    localparam logic [5:0] P_NONE = 6'b000000;
    localparam logic [5:0] P_L1   = 6'b100000;
    localparam logic [5:0] P_R1   = 6'b010000;
    localparam logic [5:0] P_B2   = 6'b000001;
    localparam logic [5:0] P_L2   = 6'b000100;
    localparam logic [5:0] P_R2   = 6'b000010;

    logic       clk;
    logic       resetn;
    logic       enable;
    logic [3:0] key_n;
    logic       left_one, right_one, both_one;
    logic       left_two, right_two, both_two;
    logic [3:0] pressed;
    logic [5:0] pulses;

    int unsigned checks   = 0;
    int unsigned failures = 0;

    key_pulse_gen #(
        .DEBOUNCE_CYCLES(4),
        .CNT_W(3)
    ) dut (
        .clk(clk),
        .resetn(resetn),
        .enable(enable),
        .key_n(key_n),
        .left_one(left_one),
        .right_one(right_one),
        .both_one(both_one),
        .left_two(left_two),
        .right_two(right_two),
        .both_two(both_two),
        .pressed(pressed)
    );

    assign pulses = {left_one, right_one, both_one, left_two, right_two, both_two};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Press from edge 0, hold n edges; pulse after edge 6, pressed after edge 5.
    task automatic press_run(input string name, input logic [3:0] kn, input int n,
                             input logic [5:0] pv, input logic [3:0] pr);
        key_n = kn;
        for (int k = 0; k < n; k++) begin
            tick();
            check($sformatf("%s_pulse_e%0d", name, k), {2'b00, pulses},
                  (k == 6) ? {2'b00, pv} : 8'h00);
            check($sformatf("%s_pressed_e%0d", name, k), {4'h0, pressed},
                  (k >= 5) ? {4'h0, pr} : 8'h00);
        end
    endtask

    // Release all keys; pressed falls after edge 5, releases never pulse.
    task automatic release_run(input string name, input logic [3:0] pr);
        key_n = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            tick();
            check($sformatf("%s_rel_pulse_e%0d", name, k), {2'b00, pulses}, 8'h00);
            check($sformatf("%s_rel_pressed_e%0d", name, k), {4'h0, pressed},
                  (k >= 5) ? 8'h00 : {4'h0, pr});
        end
    endtask

    initial begin
        logic [3:0] glitch_seq [8];

        resetn = 1'b0;
        enable = 1'b1;
        key_n  = 4'b1111;
        #1;
        check("reset_pulses", {2'b00, pulses}, 8'h00);
        check("reset_pressed", {4'h0, pressed}, 8'h00);
        repeat (2) tick();
        resetn = 1'b1;
        repeat (3) tick();
        check("idle_pulses", {2'b00, pulses}, 8'h00);

        // Single left press for player one, held 20 cycles.
        press_run("p1_left", 4'b1101, 20, P_L1, 4'b0010);
        release_run("p1_left", 4'b0010);

        // Bouncy right press: two 3-cycle lows never reach the threshold.
        glitch_seq[0] = 4'b1110; glitch_seq[1] = 4'b1110; glitch_seq[2] = 4'b1110;
        glitch_seq[3] = 4'b1111;
        glitch_seq[4] = 4'b1110; glitch_seq[5] = 4'b1110; glitch_seq[6] = 4'b1110;
        glitch_seq[7] = 4'b1111;
        for (int k = 0; k < 16; k++) begin
            key_n = (k < 8) ? glitch_seq[k] : 4'b1111;
            tick();
            check($sformatf("bounce_pulse_c%0d", k), {2'b00, pulses}, 8'h00);
            check($sformatf("bounce_pressed_c%0d", k), {4'h0, pressed}, 8'h00);
        end
        press_run("p1_right", 4'b1110, 12, P_R1, 4'b0001);
        release_run("p1_right", 4'b0001);

        // Player two left+right together -> both only.
        press_run("p2_both", 4'b0011, 10, P_B2, 4'b1100);
        release_run("p2_both", 4'b1100);

        // Player two left held, right added 6 cycles later.
        key_n = 4'b0111;
        for (int k = 0; k < 20; k++) begin
            if (k == 6) key_n = 4'b0011;
            tick();
            check($sformatf("p2_stag_pulse_e%0d", k), {2'b00, pulses},
                  (k == 6) ? {2'b00, P_L2} : (k == 12) ? {2'b00, P_R2} : 8'h00);
            check($sformatf("p2_stag_pressed_e%0d", k), {4'h0, pressed},
                  {4'h0, (k >= 5) ? 1'b1 : 1'b0, (k >= 11) ? 1'b1 : 1'b0, 2'b00});
        end
        release_run("p2_stag", 4'b1100);

        // Both players press left in the same cycle.
        press_run("cross", 4'b0101, 10, P_L1 | P_L2, 4'b1010);
        release_run("cross", 4'b1010);

        // Enable low at the pulse edge discards the press; no late pulse.
        key_n = 4'b1101;
        for (int k = 0; k < 14; k++) begin
            if (k == 6) enable = 1'b0;
            if (k == 8) enable = 1'b1;
            tick();
            check($sformatf("en_off_pulse_e%0d", k), {2'b00, pulses}, 8'h00);
        end
        release_run("en_off", 4'b0010);
        press_run("en_repress", 4'b1101, 10, P_L1, 4'b0010);
        release_run("en_repress", 4'b0010);

        // Reset asserted while the pulse is high clears everything at once.
        key_n = 4'b1101;
        for (int k = 0; k < 7; k++) tick();
        check("pre_reset_pulse", {2'b00, pulses}, {2'b00, P_L1});
        resetn = 1'b0;
        #1;
        check("async_reset_pulses", {2'b00, pulses}, 8'h00);
        check("async_reset_pressed", {4'h0, pressed}, 8'h00);
        tick();
        check("held_reset_pressed", {4'h0, pressed}, 8'h00);
        resetn = 1'b1;
        press_run("post_reset", 4'b1101, 10, P_L1, 4'b0010);
        release_run("post_reset", 4'b0010);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
